// File: rtl/alu_stack_seq_if.sv
// alu_stack_seq_if -- command channel into the ALU operand-stack sequencer.
//
// Signals:
//   cmd_valid     producer has a command this cycle
//   cmd_ready     sequencer can take a command (high only while idle)
//   cmd_kind      00 PUSH, 01 ALU, 10 DROP, 11 illegal
//   cmd_imm       value for PUSH
//   cmd_alu_ctrl  ALU opcode for ALU commands
//
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready.
// The producer holds all cmd_* fields stable while cmd_valid is high and
// cmd_ready is low; cmd_ready never depends on cmd_valid.
//
// Modports: master (decode stage) drives the command; slave (sequencer) drives
// cmd_ready.
`ifndef ST_WIDTH_DEFAULT
`define ST_WIDTH_DEFAULT 32
`endif

interface alu_stack_seq_if #(
   parameter int ST_WIDTH = `ST_WIDTH_DEFAULT
);
   logic                cmd_valid;
   logic                cmd_ready;
   logic [1:0]          cmd_kind;
   logic [ST_WIDTH-1:0] cmd_imm;
   logic [3:0]          cmd_alu_ctrl;

   modport master (
      output cmd_valid,
      output cmd_kind,
      output cmd_imm,
      output cmd_alu_ctrl,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_kind,
      input  cmd_imm,
      input  cmd_alu_ctrl,
      output cmd_ready
   );
endinterface

// File: rtl/alu_stack_seq.sv
// alu_stack_seq -- operand-stack sequencer in front of the combinational ALU.
// Accepts PUSH / DROP / ALU commands, keeps an operand stack, pops 1-3
// operands into registered ALU inputs, captures the ALU result and pushes it.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   clear             synchronous flush (depth, error flags, FSM)
//   cmd               command channel (alu_stack_seq_if.slave)
//   alu_a/b/c         registered ALU operands (a = top of stack)
//   alu_ctrl          registered ALU opcode
//   alu_result        combinational ALU result
//   top_valid         stack not empty
//   top_data          top entry, 0 when empty
//   depth             entry count 0..DEPTH
//   err_underflow/overflow/illegal  sticky error flags
//   o_dbg_state       FSM state for observation
//
// Build option: ALU_SEQ_FAST_WB_EN writes alu_result straight into the stack
// from EXEC (no WB state, no result register). Default build registers the
// result first to keep the ALU out of the stack-write timing path.
`ifndef ST_WIDTH_DEFAULT
`define ST_WIDTH_DEFAULT 32
`endif

module alu_stack_seq #(
   parameter int ST_WIDTH = `ST_WIDTH_DEFAULT,
   parameter int DEPTH    = 16,
   parameter int DW       = $clog2(DEPTH) + 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clear,
   alu_stack_seq_if.slave      cmd,
   output logic [ST_WIDTH-1:0] alu_a,
   output logic [ST_WIDTH-1:0] alu_b,
   output logic [ST_WIDTH-1:0] alu_c,
   output logic [3:0]          alu_ctrl,
   input  logic [31:0]         alu_result,
   output logic                top_valid,
   output logic [ST_WIDTH-1:0] top_data,
   output logic [DW-1:0]       depth,
   output logic                err_underflow,
   output logic                err_overflow,
   output logic                err_illegal,
   output logic [1:0]          o_dbg_state
);
   localparam int            AW      = $clog2(DEPTH);
   localparam logic [DW-1:0] DEPTH_W = DW'(DEPTH);
   localparam logic [1:0]    K_PUSH  = 2'b00;
   localparam logic [1:0]    K_ALU   = 2'b01;
   localparam logic [1:0]    K_DROP  = 2'b10;

`ifdef ALU_SEQ_FAST_WB_EN
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1} state_t;
`else
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_WB = 2'd2} state_t;
   logic [ST_WIDTH-1:0] r_result;
`endif

   state_t              r_state, w_state_next;
   logic [DW-1:0]       r_depth, w_depth_next;
   logic [ST_WIDTH-1:0] r_mem [DEPTH];
   logic [ST_WIDTH-1:0] r_alu_a, r_alu_b, r_alu_c;
   logic [3:0]          r_alu_ctrl;
   logic                r_err_uf, r_err_of, r_err_il;
   logic                w_mem_we, w_alu_load, w_set_uf, w_set_of, w_set_il;
   logic [ST_WIDTH-1:0] w_mem_wdata, w_alu_res;
   logic [DW-1:0]       w_arity;
   logic [AW-1:0]       w_idx0, w_idx1, w_idx2;

   // Stack indices wrap modulo DEPTH, so depth==DEPTH still yields top = DEPTH-1.
   assign w_idx0    = r_depth[AW-1:0] - AW'(1);
   assign w_idx1    = r_depth[AW-1:0] - AW'(2);
   assign w_idx2    = r_depth[AW-1:0] - AW'(3);
   assign w_alu_res = ST_WIDTH'(alu_result);

   assign cmd.cmd_ready = (r_state == S_IDLE);
   assign top_valid     = (r_depth != '0);
   assign top_data      = top_valid ? r_mem[w_idx0] : '0;
   assign depth         = r_depth;
   assign alu_a         = r_alu_a;
   assign alu_b         = r_alu_b;
   assign alu_c         = r_alu_c;
   assign alu_ctrl      = r_alu_ctrl;
   assign err_underflow = r_err_uf;
   assign err_overflow  = r_err_of;
   assign err_illegal   = r_err_il;
   assign o_dbg_state   = r_state;

   // select pops three operands, eqz one, everything else two.
   always_comb begin
      case (cmd.cmd_alu_ctrl)
         4'b0100: w_arity = DW'(3);
         4'b0101: w_arity = DW'(1);
         default: w_arity = DW'(2);
      endcase
   end

   always_comb begin
      w_state_next = r_state;
      w_depth_next = r_depth;
      w_mem_we     = 1'b0;
      w_mem_wdata  = cmd.cmd_imm;
      w_alu_load   = 1'b0;
      w_set_uf     = 1'b0;
      w_set_of     = 1'b0;
      w_set_il     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (cmd.cmd_valid) begin
               case (cmd.cmd_kind)
                  K_PUSH: begin
                     if (r_depth < DEPTH_W) begin
                        w_mem_we     = 1'b1;
                        w_depth_next = r_depth + DW'(1);
                     end else begin
                        w_set_of = 1'b1;
                     end
                  end
                  K_DROP: begin
                     if (r_depth != '0) w_depth_next = r_depth - DW'(1);
                     else               w_set_uf     = 1'b1;
                  end
                  K_ALU: begin
                     if (r_depth < w_arity) begin
                        w_set_uf = 1'b1;
                     end else begin
                        w_alu_load   = 1'b1;
                        w_depth_next = r_depth - w_arity;
                        w_state_next = S_EXEC;
                     end
                  end
                  default: w_set_il = 1'b1;
               endcase
            end
         end
`ifdef ALU_SEQ_FAST_WB_EN
         S_EXEC: begin
            w_mem_we     = 1'b1;
            w_mem_wdata  = w_alu_res;
            w_depth_next = r_depth + DW'(1);
            w_state_next = S_IDLE;
         end
`else
         S_EXEC: w_state_next = S_WB;
         S_WB: begin
            // At least one operand was popped, so this push always has room.
            w_mem_we     = 1'b1;
            w_mem_wdata  = r_result;
            w_depth_next = r_depth + DW'(1);
            w_state_next = S_IDLE;
         end
`endif
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     r_state <= S_IDLE;
      else if (clear) r_state <= S_IDLE;
      else            r_state <= w_state_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_depth    <= '0;
         r_err_uf   <= 1'b0;
         r_err_of   <= 1'b0;
         r_err_il   <= 1'b0;
         r_alu_a    <= '0;
         r_alu_b    <= '0;
         r_alu_c    <= '0;
         r_alu_ctrl <= '0;
`ifndef ALU_SEQ_FAST_WB_EN
         r_result   <= '0;
`endif
      end else if (clear) begin
         // Operand registers keep their last values across a flush.
         r_depth  <= '0;
         r_err_uf <= 1'b0;
         r_err_of <= 1'b0;
         r_err_il <= 1'b0;
      end else begin
         r_depth <= w_depth_next;
         if (w_set_uf) r_err_uf <= 1'b1;
         if (w_set_of) r_err_of <= 1'b1;
         if (w_set_il) r_err_il <= 1'b1;
         if (w_alu_load) begin
            r_alu_a    <= r_mem[w_idx0];
            r_alu_b    <= (w_arity >= DW'(2)) ? r_mem[w_idx1] : '0;
            r_alu_c    <= (w_arity == DW'(3)) ? r_mem[w_idx2] : '0;
            r_alu_ctrl <= cmd.cmd_alu_ctrl;
         end
`ifndef ALU_SEQ_FAST_WB_EN
         if (r_state == S_EXEC) r_result <= w_alu_res;
`endif
      end
   end

   // Stack storage has no reset; only entries below depth are ever observed.
   always_ff @(posedge clk) begin
      if (rst_n && !clear && w_mem_we) r_mem[r_depth[AW-1:0]] <= w_mem_wdata;
   end
endmodule

// File: tb/tb_alu_stack_seq.sv
// tb_alu_stack_seq -- self-checking bench for alu_stack_seq: directed cases
// with literal expectations plus randomized commands compared every cycle
// against a queue-based stack model.
module tb_alu_stack_seq;
   localparam int ST_WIDTH = 32;
   localparam int DEPTH    = 16;
   localparam int DW       = 5;
`ifdef ALU_SEQ_FAST_WB_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif
   localparam logic [1:0] PUSH = 2'b00, ALU = 2'b01, DROP = 2'b10, ILL = 2'b11;

   logic                clk   = 1'b0;
   logic                rst_n = 1'b0;
   logic                clear = 1'b0;
   logic [ST_WIDTH-1:0] alu_a, alu_b, alu_c, top_data;
   logic [3:0]          alu_ctrl;
   logic [31:0]         alu_result;
   logic                top_valid, err_underflow, err_overflow, err_illegal;
   logic [DW-1:0]       depth;
   logic [1:0]          dbg_state;

   int n_tests = 0;
   int n_fail  = 0;

   alu_stack_seq_if #(.ST_WIDTH(ST_WIDTH)) cmd_if();

   alu_stack_seq #(.ST_WIDTH(ST_WIDTH), .DEPTH(DEPTH), .DW(DW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .clear         (clear),
      .cmd           (cmd_if),
      .alu_a         (alu_a),
      .alu_b         (alu_b),
      .alu_c         (alu_c),
      .alu_ctrl      (alu_ctrl),
      .alu_result    (alu_result),
      .top_valid     (top_valid),
      .top_data      (top_data),
      .depth         (depth),
      .err_underflow (err_underflow),
      .err_overflow  (err_overflow),
      .err_illegal   (err_illegal),
      .o_dbg_state   (dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- stand-in combinational ALU ----------------
   // Binary ops compute b OP a (b = lhs, a = rhs); select = a!=0 ? c : b.
   function automatic logic [31:0] alu_fn(input logic [3:0] op,
                                          input logic [31:0] a, b, c);
      case (op)
         4'b0000: return b + a;
         4'b0001: return b - a;
         4'b0010: return b & a;
         4'b0011: return b | a;
         4'b0100: return (a != 32'd0) ? c : b;
         4'b0101: return {31'd0, a == 32'd0};
         4'b0110: return b ^ a;
         4'b0111: return {31'd0, b < a};
         4'b1011: return {31'd0, $signed(b) < $signed(a)};
         default: return b * a;
      endcase
   endfunction

   assign alu_result = alu_fn(alu_ctrl, alu_a, alu_b, alu_c);

   function automatic int arity_of(input logic [3:0] op);
      if (op == 4'b0100) return 3;
      if (op == 4'b0101) return 1;
      return 2;
   endfunction

   // ---------------- checker ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [ST_WIDTH-1:0] exp_q[$];
   bit                  m_on = 1'b0;
   bit                  m_uf, m_of, m_il;
   int                  m_busy;
   logic [31:0]         m_pend, m_a, m_b, m_c;
   logic [3:0]          m_ctrl;

   always @(posedge clk or negedge rst_n) begin
      int n;
      if (!rst_n) begin
         exp_q.delete();
         m_uf = 1'b0; m_of = 1'b0; m_il = 1'b0;
         m_busy = 0; m_pend = '0;
         m_a = '0; m_b = '0; m_c = '0; m_ctrl = '0;
         m_on = 1'b1;
      end else if (clear) begin
         exp_q.delete();
         m_uf = 1'b0; m_of = 1'b0; m_il = 1'b0;
         m_busy = 0;
      end else if (m_busy > 0) begin
         m_busy--;
         if (m_busy == 0) exp_q.push_back(m_pend);
      end else if (cmd_if.cmd_valid) begin
         case (cmd_if.cmd_kind)
            PUSH: begin
               if (exp_q.size() < DEPTH) exp_q.push_back(cmd_if.cmd_imm);
               else                      m_of = 1'b1;
            end
            DROP: begin
               if (exp_q.size() > 0) void'(exp_q.pop_back());
               else                  m_uf = 1'b1;
            end
            ALU: begin
               n = arity_of(cmd_if.cmd_alu_ctrl);
               if (exp_q.size() < n) begin
                  m_uf = 1'b1;
               end else begin
                  m_a = exp_q.pop_back();
                  m_b = 32'd0;
                  m_c = 32'd0;
                  if (n >= 2) m_b = exp_q.pop_back();
                  if (n == 3) m_c = exp_q.pop_back();
                  m_ctrl = cmd_if.cmd_alu_ctrl;
                  m_pend = alu_fn(m_ctrl, m_a, m_b, m_c);
                  m_busy = LAT;
               end
            end
            default: m_il = 1'b1;
         endcase
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (m_on) begin
         check("cmd_ready", cmd_if.cmd_ready, m_busy == 0);
         check("depth", depth, exp_q.size());
         check("top_valid", top_valid, exp_q.size() != 0);
         check("top_data", top_data, (exp_q.size() != 0) ? exp_q[$] : 32'd0);
         check("err_underflow", err_underflow, m_uf);
         check("err_overflow", err_overflow, m_of);
         check("err_illegal", err_illegal, m_il);
         check("alu_a", alu_a, m_a);
         check("alu_b", alu_b, m_b);
         check("alu_c", alu_c, m_c);
         check("alu_ctrl", alu_ctrl, m_ctrl);
      end
   end

   // ---------------- driver tasks ----------------
   // Returns #1 after the accepting edge.
   task automatic send(input logic [1:0] kind, input logic [31:0] imm,
                       input logic [3:0] op, input bit clr);
      int n = 0;
      cmd_if.cmd_valid    = 1'b1;
      cmd_if.cmd_kind     = kind;
      cmd_if.cmd_imm      = imm;
      cmd_if.cmd_alu_ctrl = op;
      @(negedge clk);
      while (!cmd_if.cmd_ready && n < 20) begin
         n++;
         @(negedge clk);
      end
      if (n >= 20) check("ready_timeout", cmd_if.cmd_ready, 1'b1);
      clear = clr;
      @(posedge clk); #1;
      cmd_if.cmd_valid = 1'b0;
      clear            = 1'b0;
   endtask

   task automatic push(input logic [31:0] v);
      send(PUSH, v, 4'd0, 1'b0);
   endtask

   task automatic do_alu(input logic [3:0] op);
      send(ALU, 32'd0, op, 1'b0);
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
   endtask

   // Waits until the sequencer is idle; returns on a negedge.
   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (!cmd_if.cmd_ready && n < 20) begin
         n++;
         @(negedge clk);
      end
      if (n >= 20) check("idle_timeout", cmd_if.cmd_ready, 1'b1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      int r;
      cmd_if.cmd_valid    = 1'b0;
      cmd_if.cmd_kind     = 2'b00;
      cmd_if.cmd_imm      = '0;
      cmd_if.cmd_alu_ctrl = 4'd0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset state
      @(negedge clk);
      check("rst_ready", cmd_if.cmd_ready, 1'b1);
      check("rst_top_valid", top_valid, 1'b0);
      check("rst_top_data", top_data, 32'd0);
      check("rst_depth", depth, 0);
      @(posedge clk); #1;

      // 7 - 5 = 2, ready low for LAT cycles
      push(32'd7);
      push(32'd5);
      do_alu(4'b0001);
      check("sub_alu_a", alu_a, 32'd5);
      check("sub_alu_b", alu_b, 32'd7);
      check("sub_depth_exec", depth, 0);
      n = 0;
      @(negedge clk);
      while (!cmd_if.cmd_ready && n < 10) begin
         n++;
         @(negedge clk);
      end
      check("sub_ready_low_cycles", n, LAT);
      check("sub_top", top_data, 32'd2);
      check("sub_depth", depth, 1);

      // select: cond=0 -> val2, cond=1 -> val1
      do_clear();
      push(32'd11); push(32'd22); push(32'd0);
      do_alu(4'b0100);
      wait_idle();
      check("sel0_top", top_data, 32'd22);
      check("sel0_depth", depth, 1);
      do_clear();
      push(32'd11); push(32'd22); push(32'd1);
      do_alu(4'b0100);
      wait_idle();
      check("sel1_top", top_data, 32'd11);

      // signed vs unsigned compare
      do_clear();
      push(32'hFFFF_FFFF); push(32'd1);
      do_alu(4'b1011);
      wait_idle();
      check("lt_s_top", top_data, 32'd1);
      do_clear();
      push(32'hFFFF_FFFF); push(32'd1);
      do_alu(4'b0111);
      wait_idle();
      check("lt_u_top", top_data, 32'd0);

      // underflow on empty stack, cleared by flush
      do_clear();
      do_alu(4'b0000);
      @(negedge clk);
      check("uf_alu_flag", err_underflow, 1'b1);
      check("uf_alu_depth", depth, 0);
      @(posedge clk); #1;
      send(DROP, 32'd0, 4'd0, 1'b0);
      @(negedge clk);
      check("uf_drop_depth", depth, 0);
      @(posedge clk); #1;
      do_clear();
      @(negedge clk);
      check("uf_cleared", err_underflow, 1'b0);
      @(posedge clk); #1;

      // fill to DEPTH, then overflow
      for (int i = 1; i <= DEPTH; i++) push(i);
      push(32'd99);
      @(negedge clk);
      check("of_flag", err_overflow, 1'b1);
      check("of_depth", depth, DEPTH);
      check("of_top", top_data, DEPTH);
      @(posedge clk); #1;

      // reset during EXEC aborts the op
      do_clear();
      push(32'd3); push(32'd4);
      do_alu(4'b0000);
      rst_n = 1'b0;
      @(negedge clk);
      check("rst_exec_depth", depth, 0);
      check("rst_exec_ready", cmd_if.cmd_ready, 1'b1);
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("rst_exec_no_push", depth, 0);
      @(posedge clk); #1;

      // clear during EXEC discards the result
      push(32'd3); push(32'd4);
      do_alu(4'b0000);
      do_clear();
      repeat (4) @(negedge clk);
      check("clr_exec_depth", depth, 0);
      check("clr_exec_top_valid", top_valid, 1'b0);
      check("clr_exec_ready", cmd_if.cmd_ready, 1'b1);
      @(posedge clk); #1;

      // randomized traffic, checked every cycle by the model
      for (int i = 0; i < 500; i++) begin
         r = $urandom_range(0, 99);
         if (r < 45)      push(($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom);
         else if (r < 55) send(DROP, 32'd0, 4'd0, 1'b0);
         else if (r < 88) do_alu(4'($urandom_range(0, 15)));
         else if (r < 91) send(ILL, $urandom, 4'($urandom_range(0, 15)), 1'b0);
         else if (r < 94) send(2'($urandom_range(0, 3)), $urandom, 4'($urandom_range(0, 15)), 1'b1);
         else if (r < 96) do_clear();
         else begin
            repeat ($urandom_range(1, 3)) begin
               @(posedge clk); #1;
            end
         end
      end
      wait_idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
